// File: rtl/elastic_pipe_if.sv
// Handshake bundle for elastic_pipe: upstream valid/ready/data, downstream
// valid/ready/data, flush and occupancy. "slave" is the pipe side.
interface elastic_pipe_if #(
  parameter int WIDTH = 16,
  parameter int STAGE = 2
);
  logic                         flush;
  logic                         in_valid;
  logic [WIDTH-1:0]             in_data;
  logic                         in_ready;
  logic                         out_valid;
  logic [WIDTH-1:0]             out_data;
  logic                         out_ready;
  logic [$clog2(STAGE+1)-1:0]   count;

  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count
  );

  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count
  );
endinterface

// File: rtl/elastic_pipe.sv
// Elastic register pipeline of STAGE valid/data stages. The ready chain is
// combinational from out_ready, so gaps collapse while the output is stalled.
module elastic_pipe #(
  parameter int WIDTH = 16,
  parameter int STAGE = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  elastic_pipe_if.slave bus
);
  localparam int CW = $clog2(STAGE + 1);

  logic [STAGE-1:0]            vld;
  logic [STAGE-1:0][WIDTH-1:0] dat;
  logic [STAGE-1:0]            take;
  logic [CW-1:0]               occ;
  logic                        free;

  // take[i]: stage i may load this cycle because it is empty or its word moves on
  always_comb begin
    free = bus.out_ready;
    take = '0;
    for (int i = STAGE - 1; i >= 0; i--) begin
      take[i] = !vld[i] || free;
      free    = take[i];
    end
  end

  always_comb begin
    occ = '0;
    for (int i = 0; i < STAGE; i++) begin
      occ = occ + CW'(vld[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      dat <= '0;
    end else if (bus.flush) begin
      vld <= '0;
    end else begin
      if (take[0]) begin
        vld[0] <= bus.in_valid;
        if (bus.in_valid) begin
          dat[0] <= bus.in_data;
        end
      end
      // A stage that loads from an empty predecessor becomes empty itself
      for (int i = 1; i < STAGE; i++) begin
        if (take[i]) begin
          vld[i] <= vld[i-1];
          if (vld[i-1]) begin
            dat[i] <= dat[i-1];
          end
        end
      end
    end
  end

  assign bus.in_ready  = !bus.flush && take[0];
  assign bus.out_valid = vld[STAGE-1];
  assign bus.out_data  = dat[STAGE-1];
  assign bus.count     = occ;
endmodule

// File: tb/tb_elastic_pipe.sv
// Self-checking bench for elastic_pipe (STAGE=2, WIDTH=16): directed vector
// table, hand-written reset/stream sequences, then random traffic vs a queue model.
module tb_elastic_pipe;
  localparam int WIDTH = 16;
  localparam int STAGE = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  elastic_pipe_if #(.WIDTH(WIDTH), .STAGE(STAGE)) bus ();

  elastic_pipe #(.WIDTH(WIDTH), .STAGE(STAGE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        flush;
    logic        in_valid;
    logic [15:0] in_data;
    logic        out_ready;
    logic        exp_in_ready;
    logic        exp_out_valid;
    logic [15:0] exp_out_data;
    int          exp_count;
  } vec_t;

  typedef struct {
    logic [15:0] data;
    int          pos;
  } word_t;

  vec_t  tbl[$];
  word_t mq[$];

  function automatic void add(input logic f, input logic iv, input logic [15:0] d,
                              input logic orr, input logic eir, input logic eov,
                              input logic [15:0] eod, input int ecnt);
    tbl.push_back('{f, iv, d, orr, eir, eov, eod, ecnt});
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic eir, input logic eov,
                           input logic [15:0] eod, input int ecnt);
    check_output({tag, " in_ready"}, 32'(bus.in_ready), 32'(eir));
    check_output({tag, " out_valid"}, 32'(bus.out_valid), 32'(eov));
    if (eov) begin
      check_output({tag, " out_data"}, 32'(bus.out_data), 32'(eod));
    end
    check_output({tag, " count"}, 32'(bus.count), ecnt);
  endtask

  task automatic apply_stimulus(input logic f, input logic iv, input logic [15:0] d, input logic orr);
    bus.flush     = f;
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.out_ready = orr;
    #1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference: ordered queue of words, each with its distance from the input
  function automatic logic m_out_valid();
    if (mq.size() == 0) return 1'b0;
    return mq[0].pos == STAGE - 1;
  endfunction

  function automatic logic m_in_ready(input logic f, input logic orr);
    return !f && !(mq.size() == STAGE && !orr);
  endfunction

  task automatic model_edge(input logic f, input logic iv, input logic [15:0] d, input logic orr);
    logic  ir;
    logic  pop;
    word_t w;
    int    lim;
    ir  = m_in_ready(f, orr);
    pop = m_out_valid() && orr;
    if (pop) void'(mq.pop_front());
    if (f) begin
      mq.delete();
    end else begin
      for (int j = 0; j < mq.size(); j++) begin
        w   = mq[j];
        lim = (j == 0) ? STAGE - 1 : mq[j-1].pos - 1;
        w.pos = (w.pos + 1 < lim) ? w.pos + 1 : lim;
        mq[j] = w;
      end
      if (iv && ir) mq.push_back('{data: d, pos: 0});
    end
  endtask

  initial begin
    logic        f, iv, orr;
    logic [15:0] d;
    int          thr;

    apply_stimulus(1'b0, 1'b0, 16'h0, 1'b0);
    repeat (2) @(negedge clk);
    check_all("reset", 1'b1, 1'b0, 16'h0, 0);
    check_output("reset out_data", 32'(bus.out_data), 32'h0);
    rst_n = 1'b1;

    // latency, backpressure, bubble collapse, flush
    add(0, 1, 16'h1234, 1, 1, 0, 16'h0,    0);
    add(0, 0, 16'h0,    1, 1, 0, 16'h0,    1);
    add(0, 0, 16'h0,    1, 1, 1, 16'h1234, 1);
    add(0, 0, 16'h0,    1, 1, 0, 16'h0,    0);
    add(0, 1, 16'hA,    0, 1, 0, 16'h0,    0);
    add(0, 1, 16'hB,    0, 1, 0, 16'h0,    1);
    add(0, 1, 16'hC,    0, 0, 1, 16'hA,    2);
    add(0, 1, 16'hC,    0, 0, 1, 16'hA,    2);
    add(0, 1, 16'hC,    1, 1, 1, 16'hA,    2);
    add(0, 0, 16'h0,    1, 1, 1, 16'hB,    2);
    add(0, 0, 16'h0,    1, 1, 1, 16'hC,    1);
    add(0, 0, 16'h0,    0, 1, 0, 16'h0,    0);
    add(0, 1, 16'h5,    0, 1, 0, 16'h0,    0);
    add(0, 0, 16'h0,    0, 1, 0, 16'h0,    1);
    add(0, 1, 16'h6,    0, 1, 1, 16'h5,    1);
    add(0, 0, 16'h0,    0, 0, 1, 16'h5,    2);
    add(0, 0, 16'h0,    0, 0, 1, 16'h5,    2);
    add(0, 0, 16'h0,    1, 1, 1, 16'h5,    2);
    add(0, 0, 16'h0,    1, 1, 1, 16'h6,    1);
    add(0, 0, 16'h0,    0, 1, 0, 16'h0,    0);
    add(0, 1, 16'h7,    0, 1, 0, 16'h0,    0);
    add(0, 1, 16'h8,    0, 1, 0, 16'h0,    1);
    add(1, 1, 16'h9,    0, 0, 1, 16'h7,    2);
    add(0, 0, 16'h0,    0, 1, 0, 16'h0,    0);
    add(1, 1, 16'h33,   1, 0, 0, 16'h0,    0);
    add(0, 0, 16'h0,    1, 1, 0, 16'h0,    0);
    add(0, 0, 16'h0,    1, 1, 0, 16'h0,    0);

    for (int k = 0; k < tbl.size(); k++) begin
      apply_stimulus(tbl[k].flush, tbl[k].in_valid, tbl[k].in_data, tbl[k].out_ready);
      check_all($sformatf("vec%0d", k), tbl[k].exp_in_ready, tbl[k].exp_out_valid,
                tbl[k].exp_out_data, tbl[k].exp_count);
      next_cycle();
    end

    // back-to-back streaming of words 1..10
    for (int c = 0; c < 12; c++) begin
      apply_stimulus(1'b0, c < 10, 16'(c + 1), 1'b1);
      check_output($sformatf("stream%0d in_ready", c), 32'(bus.in_ready), 32'h1);
      check_output($sformatf("stream%0d out_valid", c), 32'(bus.out_valid), (c >= 2) ? 32'h1 : 32'h0);
      if (c >= 2) begin
        check_output($sformatf("stream%0d out_data", c), 32'(bus.out_data), c - 1);
      end
      next_cycle();
    end
    check_all("stream_end", 1'b1, 1'b0, 16'h0, 0);

    // asynchronous reset while two words are held
    apply_stimulus(1'b0, 1'b1, 16'h21, 1'b0);
    next_cycle();
    apply_stimulus(1'b0, 1'b1, 16'h22, 1'b0);
    next_cycle();
    check_all("pre_rst", 1'b0, 1'b1, 16'h21, 2);
    rst_n = 1'b0;
    #1;
    check_all("rst_mid", 1'b1, 1'b0, 16'h0, 0);
    check_output("rst_mid out_data", 32'(bus.out_data), 32'h0);
    apply_stimulus(1'b0, 1'b1, 16'h55, 1'b1);
    next_cycle();
    check_all("rst_hold", 1'b1, 1'b0, 16'h0, 0);
    rst_n = 1'b1;
    apply_stimulus(1'b0, 1'b1, 16'h42, 1'b1);
    check_all("post_rst0", 1'b1, 1'b0, 16'h0, 0);
    next_cycle();
    apply_stimulus(1'b0, 1'b0, 16'h0, 1'b1);
    check_all("post_rst1", 1'b1, 1'b0, 16'h0, 1);
    next_cycle();
    check_all("post_rst2", 1'b1, 1'b1, 16'h42, 1);
    next_cycle();
    check_all("post_rst3", 1'b1, 1'b0, 16'h0, 0);

    // random traffic against the queue model; pipe is empty here
    mq.delete();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      thr = (((cyc / 250) % 3) == 0) ? 2 : ((((cyc / 250) % 3) == 1) ? 5 : 9);
      f   = ($urandom_range(0, 19) == 0);
      iv  = ($urandom_range(0, 9) < 7);
      d   = 16'($urandom);
      orr = ($urandom_range(0, 9) < thr);
      apply_stimulus(f, iv, d, orr);
      check_all("rand", m_in_ready(f, orr), m_out_valid(),
                (mq.size() > 0) ? mq[0].data : 16'h0, mq.size());
      model_edge(f, iv, d, orr);
      next_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
